// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver (LSB first) with a held valid/ack byte handshake.
//
// The raw line goes through a 2-flop synchronizer. Each bit is resolved by a 3-sample
// majority vote around mid-bit. The vote rejects single-cycle glitches and false starts.
//
// Ports:
//   clk      in   single clock, all state on posedge
//   n_reset  in   asynchronous active-low reset
//   rx       in   raw UART line, idle high, asynchronous to clk
//   data     out  received byte, stable while valid is high
//   valid    out  byte available, held until accepted with ack
//   ack      in   consumer accepts byte; ignored while valid is low
//   overrun  out  sticky: a completed byte was dropped because valid was still set
//   ferr     out  one-cycle pulse when the stop bit is sampled low
//   busy     out  receiver is not idle
//
// CLK_HZ / BAUD must be at least 8.
module uart_byte_rx #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       overrun,
    output logic       ferr,
    output logic       busy
);

    localparam int unsigned Div     = CLK_HZ / BAUD;
    localparam int unsigned HalfDiv = Div / 2;
    localparam int unsigned Tw      = (Div > 1) ? $clog2(Div) : 1;

    localparam logic [Tw-1:0] TSamp0  = Tw'(HalfDiv - 1);
    localparam logic [Tw-1:0] TSamp1  = Tw'(HalfDiv);
    localparam logic [Tw-1:0] TDecide = Tw'(HalfDiv + 1);
    localparam logic [Tw-1:0] TLast   = Tw'(Div - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    logic          rx_meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [Tw-1:0] t_q, t_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;

    logic          maj;
    logic          at_decide;
    logic          at_last;
    logic          deliver;
    logic [Tw-1:0] t_inc;

    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign at_decide = (t_q == TDecide);
    assign at_last   = (t_q == TLast);
    assign t_inc     = at_last ? '0 : t_q + Tw'(1);

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        idx_d     = idx_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = 1'b0;
        deliver   = 1'b0;

        // The first two votes are captured early; the third is live rx_s at the decision.
        if (t_q == TSamp0) samp_d[0] = rx_s_q;
        if (t_q == TSamp1) samp_d[1] = rx_s_q;

        case (state_q)
            StIdle: begin
                t_d   = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                t_d = t_inc;
                if (at_decide && maj) begin
                    state_d = StIdle;
                    t_d     = '0;
                end else if (at_last) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                t_d = t_inc;
                if (at_decide) shreg_d[idx_q] = maj;
                if (at_last) begin
                    if (idx_q == 3'd7) state_d = StStop;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            StStop: begin
                t_d = t_inc;
                // Resolve at mid stop bit so a following start edge is not missed.
                if (at_decide) begin
                    t_d = '0;
                    if (maj) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                t_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
                idx_d   = '0;
            end
        endcase

        if (deliver) begin
            if (!valid_q || ack) begin
                data_d    = shreg_q;
                valid_d   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            t_q       <= '0;
            idx_q     <= '0;
            samp_q    <= 2'b11;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            t_q       <= t_d;
            idx_q     <= idx_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign ferr    = ferr_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at DIV=10, M=5.
// Each rx level is set on a falling clock edge. The rx_s path adds two edges, so the first
// edge sampling rx_s=0 is P3. Valid is therefore expected on edge P100, which is 97 edges later.
module tb_uart_byte_rx;

    logic       clk;
    logic       n_reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic       overrun;
    logic       ferr;
    logic       busy;

    int n_vec;
    int n_err;

    uart_byte_rx #(
        .CLK_HZ(1000000),
        .BAUD  (100000)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .rx     (rx),
        .data   (data),
        .valid  (valid),
        .ack    (ack),
        .overrun(overrun),
        .ferr   (ferr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame, 10 cycles per bit, then tail_low extra low cycles, then 12 idle cycles.
    // Reports the index of the falling edge at which valid rose, or -1, and the number of
    // cycles ferr was high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_k,
                              input int ack_k, input int tail_low,
                              output int first_valid, output int ferr_cnt);
        logic prev;
        logic bitv;
        int   n;
        n           = 100 + tail_low + 12;
        first_valid = -1;
        ferr_cnt    = 0;
        prev        = valid;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (valid && !prev && first_valid < 0) first_valid = k;
            prev = valid;
            if (ferr) ferr_cnt++;
            if (k < 10)                  bitv = 1'b0;
            else if (k < 90)             bitv = b[(k - 10) / 10];
            else if (k < 100)            bitv = stop_bit;
            else if (k < 100 + tail_low) bitv = 1'b0;
            else                         bitv = 1'b1;
            if (k == glitch_k) bitv = ~bitv;
            rx  = bitv;
            ack = (k == ack_k);
        end
        rx  = 1'b1;
        ack = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b1;
        rx      = 1'b1;
        ack     = 1'b0;
        #3 n_reset = 1'b0;
        #1;
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int fv, fc;
        send_frame(8'hA5, 1'b1, -1, -1, 0, fv, fc);
        n_vec++; if (fv != 100) begin n_err++; $display("FAIL basic_latency: got %0d want 100", fv); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", data); end
        n_vec++; if (fc != 0) begin n_err++; $display("FAIL basic_ferr: got %0d want 0", fc); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL basic_overrun: got %b want 0", overrun); end
        ack_pulse();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_ack: valid got %b want 0", valid); end
    endtask

    task automatic test_glitch();
        int fv, fc;
        // Falling edge 46 lands on t=M of data bit 3.
        send_frame(8'h5A, 1'b1, 46, -1, 0, fv, fc);
        n_vec++; if (data !== 8'h5A) begin n_err++; $display("FAIL glitch_data: got %h want 5a", data); end
        n_vec++; if (fv != 100) begin n_err++; $display("FAIL glitch_latency: got %0d want 100", fv); end
        ack_pulse();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL glitch_ack: valid got %b want 0", valid); end
    endtask

    task automatic test_false_start();
        int vcnt;
        vcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (k == 5) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fstart_busy_hi: got %b want 1", busy); end
            end
            if (k == 9) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fstart_busy_t6: got %b want 1", busy); end
            end
            if (k == 10) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fstart_busy_lo: got %b want 0", busy); end
            end
            rx = (k < 3) ? 1'b0 : 1'b1;
        end
        n_vec++; if (vcnt != 0) begin n_err++; $display("FAIL fstart_valid: got %0d cycles want 0", vcnt); end
    endtask

    task automatic test_framing();
        int fv, fc;
        send_frame(8'h81, 1'b0, -1, -1, 30, fv, fc);
        n_vec++; if (fc != 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", fc); end
        n_vec++; if (fv != -1) begin n_err++; $display("FAIL ferr_novalid: got %0d want -1", fv); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit: busy got %b want 0", busy); end
        send_frame(8'h3C, 1'b1, -1, -1, 0, fv, fc);
        n_vec++; if (data !== 8'h3C) begin n_err++; $display("FAIL ferr_next_data: got %h want 3c", data); end
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ferr_next_valid: got %b want 1", valid); end
        n_vec++; if (fc != 0) begin n_err++; $display("FAIL ferr_next_ferr: got %0d want 0", fc); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        int fv, fc;
        send_frame(8'h11, 1'b1, -1, -1, 0, fv, fc);
        send_frame(8'h22, 1'b1, -1, -1, 0, fv, fc);
        n_vec++; if (data !== 8'h11) begin n_err++; $display("FAIL ovr_data: got %h want 11", data); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid); end
        ack_pulse();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack_valid: got %b want 0", valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_ack_flag: got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        int fv, fc;
        send_frame(8'h11, 1'b1, -1, -1, 0, fv, fc);
        // Ack is set on falling edge 99, so it is high at delivery edge P100.
        send_frame(8'h22, 1'b1, -1, 99, 0, fv, fc);
        n_vec++; if (data !== 8'h22) begin n_err++; $display("FAIL coinc_data: got %h want 22", data); end
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL coinc_valid: got %b want 1", valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL coinc_overrun: got %b want 0", overrun); end
        ack_pulse();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL coinc_ack: valid got %b want 0", valid); end
    endtask

    task automatic test_reset_midframe();
        int fv, fc;
        send_frame(8'h77, 1'b1, -1, -1, 0, fv, fc);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", valid); end
        for (int k = 0; k <= 55; k++) begin
            @(negedge clk);
            if (k == 55) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
                n_reset = 1'b0;
                rx      = 1'b1;
                #1;
                n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", data); end
                n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
                n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
                n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL rst_mid_ferr: got %b want 0", ferr); end
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
            end else begin
                rx = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hFF, 1'b1, -1, -1, 0, fv, fc);
        n_vec++; if (fv != 100) begin n_err++; $display("FAIL rst_next_latency: got %0d want 100", fv); end
        n_vec++; if (data !== 8'hFF) begin n_err++; $display("FAIL rst_next_data: got %h want ff", data); end
        ack_pulse();
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n_reset = 1'b1;
        rx      = 1'b1;
        ack     = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_false_start();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
